// File: rtl/mac_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_mul_pipe
//  Description : Pipelined Wallace-tree multiplier for the MAC datapath.
//                Signed or unsigned per transaction, valid/ready input with
//                a tag sideband, global-stall output backpressure, and a
//                synchronous flush. Stage chain:
//                input reg -> partial-product reg -> CSA regs -> CPA reg.
//                End-to-end latency is 2 + ceil(N_LVL/CSA_PER_STG) + 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_mul_pipe #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH,
  parameter int CSA_PER_STG  = 1,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic [INPUT_WIDTH-1:0]  i_mul_a,
  input  logic [INPUT_WIDTH-1:0]  i_mul_b,
  input  logic                    i_mul_signed,
  input  logic [TAG_WIDTH-1:0]    i_mul_tag,
  input  logic                    i_mul_valid,
  output logic                    o_mul_ready,
  output logic [OUTPUT_WIDTH-1:0] o_mul_val,
  output logic [TAG_WIDTH-1:0]    o_mul_tag,
  output logic                    o_mul_valid,
  input  logic                    i_mul_ready,
  output logic                    o_busy
);

  localparam int W  = INPUT_WIDTH;
  localparam int W2 = OUTPUT_WIDTH;

  typedef logic [W-1:0][W2-1:0] rows_t;

  // Rows remaining after a given number of 3:2 levels, starting from W rows.
  function automatic int lvl_rows(input int lvls);
    int n;
    n = W;
    for (int l = 0; l < lvls; l++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  // Number of 3:2 levels needed to bring w rows down to 2.
  function automatic int count_lvls(input int w);
    int n;
    int c;
    n = w;
    c = 0;
    for (int l = 0; l < w; l++) begin
      if (n > 2) begin
        n = (n / 3) * 2 + (n % 3);
        c++;
      end
    end
    return c;
  endfunction

  // One 3:2 level on n live rows; results are packed low, dead rows zeroed.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    g;
    o = '0;
    g = n / 3;
    for (int i = 0; i < W / 3; i++) begin
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) |
                    (r[3*i+1] & r[3*i+2])) << 1;
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (j < n % 3) o[2*g+j] = r[3*g+j];
    end
    return o;
  endfunction

  // Final carry-propagate add; only rows 0 and 1 are live after the tree.
  function automatic logic [W2-1:0] cpa(input rows_t r, input logic cin);
    return r[0] + r[1] + {{(W2-1){1'b0}}, cin};
  endfunction

  localparam int N_LVL = count_lvls(W);
  localparam int N_STG = (N_LVL + CSA_PER_STG - 1) / CSA_PER_STG;

  logic                 stall;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 sgn_q, sgn_d, v0_q, v0_d;
  logic [TAG_WIDTH-1:0] tag0_q, tag0_d;
  logic [W2-1:0]        a_ext;
  rows_t                pp_rows, pp_q, pp_d;
  logic                 pp_cin, pp_cin_q, pp_cin_d, pp_v_q, pp_v_d;
  logic [TAG_WIDTH-1:0] pp_tag_q, pp_tag_d;
  rows_t                fin_rows;
  logic                 fin_cin, fin_v;
  logic [TAG_WIDTH-1:0] fin_tag;
  logic [W2-1:0]        prod_q, prod_d;
  logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
  logic                 out_v_q, out_v_d, busy_q, busy_d;
  logic [N_STG-1:0]     stg_v_d;

  assign stall       = out_v_q & ~i_mul_ready;
  assign o_mul_ready = ~stall;

  // Partial products; a signed top row is inverted and its +1 rides as carry-in.
  always_comb begin
    a_ext   = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    pp_rows = '0;
    for (int i = 0; i < W; i++) begin
      if (b_q[i]) pp_rows[i] = a_ext << i;
    end
    if (sgn_q) pp_rows[W-1] = b_q[W-1] ? ~(a_ext << (W-1)) : '0;
    pp_cin = sgn_q & b_q[W-1];
  end

  generate
    for (genvar s = 0; s < N_STG; s++) begin : g_stg
      localparam int N0 = lvl_rows(s * CSA_PER_STG);
      rows_t                rows_in, red, rows_d, rows_q;
      logic                 cin_in, cin_d, cin_q, v_in, v_d, v_q;
      logic [TAG_WIDTH-1:0] tag_in, tag_d, tag_q;
      int                   n_rows;

      if (s == 0) begin : g_head
        assign rows_in = pp_q;
        assign cin_in  = pp_cin_q;
        assign tag_in  = pp_tag_q;
        assign v_in    = pp_v_q;
      end else begin : g_body
        assign rows_in = g_stg[s-1].rows_q;
        assign cin_in  = g_stg[s-1].cin_q;
        assign tag_in  = g_stg[s-1].tag_q;
        assign v_in    = g_stg[s-1].v_q;
      end

      // Apply this stage's share of CSA levels, then advance unless stalled.
      always_comb begin
        red    = rows_in;
        n_rows = N0;
        for (int k = 0; k < CSA_PER_STG; k++) begin
          if (s * CSA_PER_STG + k < N_LVL) begin
            red    = csa_level(red, n_rows);
            n_rows = (n_rows / 3) * 2 + (n_rows % 3);
          end
        end
        rows_d = rows_q;
        cin_d  = cin_q;
        tag_d  = tag_q;
        v_d    = v_q;
        if (!stall) begin
          rows_d = red;
          cin_d  = cin_in;
          tag_d  = tag_in;
          v_d    = v_in;
        end
        if (i_flush) v_d = 1'b0;
      end

      // CSA stage register.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          rows_q <= '0;
          cin_q  <= 1'b0;
          tag_q  <= '0;
          v_q    <= 1'b0;
        end else begin
          rows_q <= rows_d;
          cin_q  <= cin_d;
          tag_q  <= tag_d;
          v_q    <= v_d;
        end
      end

      assign stg_v_d[s] = v_d;
    end
  endgenerate

  assign fin_rows = g_stg[N_STG-1].rows_q;
  assign fin_cin  = g_stg[N_STG-1].cin_q;
  assign fin_tag  = g_stg[N_STG-1].tag_q;
  assign fin_v    = g_stg[N_STG-1].v_q;

  // Next state of input, partial-product and output stages plus busy.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    tag0_d    = tag0_q;
    v0_d      = v0_q;
    pp_d      = pp_q;
    pp_cin_d  = pp_cin_q;
    pp_tag_d  = pp_tag_q;
    pp_v_d    = pp_v_q;
    prod_d    = prod_q;
    out_tag_d = out_tag_q;
    out_v_d   = out_v_q;
    if (!stall) begin
      a_d       = i_mul_a;
      b_d       = i_mul_b;
      sgn_d     = i_mul_signed;
      tag0_d    = i_mul_tag;
      v0_d      = i_mul_valid;
      pp_d      = pp_rows;
      pp_cin_d  = pp_cin;
      pp_tag_d  = tag0_q;
      pp_v_d    = v0_q;
      prod_d    = cpa(fin_rows, fin_cin);
      out_tag_d = fin_tag;
      out_v_d   = fin_v;
    end
    if (i_flush) begin
      v0_d    = 1'b0;
      pp_v_d  = 1'b0;
      out_v_d = 1'b0;
    end
    busy_d = v0_d | pp_v_d | (|stg_v_d) | out_v_d;
  end

  // Input, partial-product and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      tag0_q    <= '0;
      v0_q      <= 1'b0;
      pp_q      <= '0;
      pp_cin_q  <= 1'b0;
      pp_tag_q  <= '0;
      pp_v_q    <= 1'b0;
      prod_q    <= '0;
      out_tag_q <= '0;
      out_v_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      tag0_q    <= tag0_d;
      v0_q      <= v0_d;
      pp_q      <= pp_d;
      pp_cin_q  <= pp_cin_d;
      pp_tag_q  <= pp_tag_d;
      pp_v_q    <= pp_v_d;
      prod_q    <= prod_d;
      out_tag_q <= out_tag_d;
      out_v_q   <= out_v_d;
      busy_q    <= busy_d;
    end
  end

  assign o_mul_val   = prod_q;
  assign o_mul_tag   = out_tag_q;
  assign o_mul_valid = out_v_q;
  assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_mul_pipe
//  Description : Directed + random bench for mac_mul_pipe with a queue
//                scoreboard (W=16/CSA=1 main, plus W=8/CSA=2 and W=32/CSA=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_mul_pipe;

  localparam int LAT   = 9;
  localparam int LAT8  = 5;
  localparam int LAT32 = 6;

  typedef struct packed {
    logic [63:0] v;
    logic [3:0]  t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic [15:0] a, b;
  logic        sgn, vin, dready, rdy, ovalid, busy;
  logic [3:0]  tag, otag;
  logic [31:0] val;

  logic [7:0]  a8, b8;
  logic        s8, v8, r8, rdy8, ov8, busy8;
  logic [3:0]  t8, ot8;
  logic [15:0] val8;

  logic [31:0] a32, b32;
  logic        s32, v32, r32, rdy32, ov32, busy32;
  logic [3:0]  t32, ot32;
  logic [63:0] val32;

  mac_mul_pipe #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(32), .CSA_PER_STG(1), .TAG_WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_mul_a(a), .i_mul_b(b), .i_mul_signed(sgn), .i_mul_tag(tag), .i_mul_valid(vin),
    .o_mul_ready(rdy), .o_mul_val(val), .o_mul_tag(otag), .o_mul_valid(ovalid),
    .i_mul_ready(dready), .o_busy(busy)
  );

  mac_mul_pipe #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .CSA_PER_STG(2), .TAG_WIDTH(4)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_mul_a(a8), .i_mul_b(b8), .i_mul_signed(s8), .i_mul_tag(t8), .i_mul_valid(v8),
    .o_mul_ready(rdy8), .o_mul_val(val8), .o_mul_tag(ot8), .o_mul_valid(ov8),
    .i_mul_ready(r8), .o_busy(busy8)
  );

  mac_mul_pipe #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .CSA_PER_STG(3), .TAG_WIDTH(4)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_mul_a(a32), .i_mul_b(b32), .i_mul_signed(s32), .i_mul_tag(t32), .i_mul_valid(v32),
    .o_mul_ready(rdy32), .o_mul_val(val32), .o_mul_tag(ot32), .o_mul_valid(ov32),
    .i_mul_ready(r32), .o_busy(busy32)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t q32[$];
  exp_t e16, e8, e32;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference product mod 2^(2w), operands zero- or sign-extended to 64 bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input int w);
    logic [63:0] m, ex, ey, p;
    m  = (64'd1 << w) - 64'd1;
    ex = x & m;
    ey = y & m;
    if (s && ex[w-1]) ex = ex | ~m;
    if (s && ey[w-1]) ey = ey | ~m;
    p = ex * ey;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Scoreboards: a product is compared in the cycle it is taken.
  always @(negedge clk) begin
    if (rst_n && ovalid && dready) begin
      if (q16.size() == 0) check("main_spurious_valid", 64'(ovalid), 64'd0);
      else begin
        e16 = q16.pop_front();
        check("main_val", 64'(val), e16.v);
        check("main_tag", 64'(otag), 64'(e16.t));
      end
    end
    if (rst_n && ov8 && r8) begin
      if (q8.size() == 0) check("w8_spurious_valid", 64'(ov8), 64'd0);
      else begin
        e8 = q8.pop_front();
        check("w8_val", 64'(val8), e8.v);
        check("w8_tag", 64'(ot8), 64'(e8.t));
      end
    end
    if (rst_n && ov32 && r32) begin
      if (q32.size() == 0) check("w32_spurious_valid", 64'(ov32), 64'd0);
      else begin
        e32 = q32.pop_front();
        check("w32_val", val32, e32.v);
        check("w32_tag", 64'(ot32), 64'(e32.t));
      end
    end
  end

  // Present one pair to the main DUT for one accepting edge; called #1 after an edge.
  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [3:0] t, input logic [63:0] expv);
    exp_t e;
    check("send_ready", 64'(rdy), 64'd1);
    a = x; b = y; sgn = s; tag = t; vin = 1'b1;
    e.v = expv;
    e.t = t;
    q16.push_back(e);
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  // Cycles from accept to o_mul_valid, with the accept cycle counted as 1.
  task automatic lat16(output int n);
    n = 1;
    while (!ovalid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain16(input string name);
    int k;
    k = 0;
    while (q16.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(q16.size()), 64'd0);
  endtask

  initial begin
    int          n, l8, l32, nv, k;
    logic [15:0] x, y;
    logic [31:0] held;
    exp_t        e;

    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; a = '0; b = '0; sgn = 1'b0; tag = '0; dready = 1'b1;
    a8 = '0; b8 = '0; s8 = 1'b0; t8 = '0; v8 = 1'b0; r8 = 1'b1;
    a32 = '0; b32 = '0; s32 = 1'b0; t32 = '0; v32 = 1'b0; r32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(ovalid), 64'd0);
    check("rst_val", 64'(val), 64'd0);
    check("rst_tag", 64'(otag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(rdy), 64'd1);
    check("rst_ready_w8", 64'(rdy8), 64'd1);
    check("rst_ready_w32", 64'(rdy32), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner products.
    send16(16'hFFFF, 16'hFFFF, 1'b0, 4'h1, 64'hFFFE0001);
    lat16(n);
    check("lat_unsigned_ffff", 64'(n), 64'(LAT));
    drain16("drain_first");
    send16(16'hFFFF, 16'h0001, 1'b0, 4'h2, 64'h0000FFFF);
    send16(16'h8000, 16'h8000, 1'b1, 4'h3, 64'h40000000);
    send16(16'hFFFF, 16'h0001, 1'b1, 4'h4, 64'hFFFFFFFF);
    send16(16'h7FFF, 16'h8000, 1'b1, 4'h5, 64'hC0008000);
    drain16("drain_directed");

    // 100 back-to-back random pairs, alternating mode, tags wrapping.
    for (int i = 0; i < 100; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      send16(x, y, i[0], 4'(i), ref_mul(64'(x), 64'(y), i[0], 16));
    end
    repeat (LAT - 2) @(posedge clk);
    @(negedge clk); #1;
    check("b2b_last_pending", 64'(q16.size()), 64'd1);
    @(posedge clk);
    @(negedge clk); #1;
    check("b2b_drained_on_time", 64'(q16.size()), 64'd0);
    @(posedge clk); #1;

    // Stream with a 5-cycle downstream stall.
    held = '0;
    for (int i = 0; i < 20; i++) begin
      dready = (i >= 12 && i < 17) ? 1'b0 : 1'b1;
      if (i == 12) held = val;
      if (i > 12 && i < 17) begin
        check("stall_ready_low", 64'(rdy), 64'd0);
        check("stall_val_held", 64'(val), 64'(held));
        check("stall_valid_held", 64'(ovalid), 64'd1);
      end
      if (i < 12) begin
        x = 16'($urandom);
        y = 16'($urandom);
        a = x; b = y; sgn = i[1]; tag = 4'(i); vin = 1'b1;
        e.v = ref_mul(64'(x), 64'(y), i[1], 16);
        e.t = 4'(i);
        q16.push_back(e);
      end else vin = 1'b0;
      @(posedge clk); #1;
    end
    dready = 1'b1;
    drain16("drain_stall");

    // Flush with 4 in flight; the pair offered alongside the flush is dropped.
    for (int i = 0; i < 4; i++) begin
      x = 16'($urandom);
      send16(x, 16'h0003, 1'b0, 4'(i), ref_mul(64'(x), 64'd3, 1'b0, 16));
    end
    check("busy_inflight", 64'(busy), 64'd1);
    flush = 1'b1; vin = 1'b1; a = 16'd7; b = 16'd7; sgn = 1'b0; tag = 4'hF;
    @(posedge clk); #1;
    flush = 1'b0; vin = 1'b0;
    q16.delete();
    check("flush_busy", 64'(busy), 64'd0);
    nv = 0;
    for (int i = 0; i < LAT; i++) begin
      nv += int'(ovalid);
      @(posedge clk); #1;
    end
    check("flush_quiet", 64'(nv), 64'd0);
    send16(16'd3, 16'd5, 1'b0, 4'hA, 64'd15);
    lat16(n);
    check("lat_after_flush", 64'(n), 64'(LAT));
    drain16("drain_flush");

    // Reset for one cycle with 6 in flight.
    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom);
      send16(x, x, 1'b1, 4'(i + 6), ref_mul(64'(x), 64'(x), 1'b1, 16));
    end
    dready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q16.delete();
    check("midrst_valid", 64'(ovalid), 64'd0);
    check("midrst_val", 64'(val), 64'd0);
    check("midrst_tag", 64'(otag), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(rdy), 64'd1);
    dready = 1'b1;
    nv = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      nv += int'(ovalid);
      @(posedge clk); #1;
    end
    check("midrst_quiet", 64'(nv), 64'd0);

    // Parameter sweep: latency, then random mixed-mode traffic.
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1; t8 = 4'h3; v8 = 1'b1;
    a32 = 32'h80000000; b32 = 32'h80000000; s32 = 1'b1; t32 = 4'h9; v32 = 1'b1;
    e.v = 64'h0001; e.t = 4'h3; q8.push_back(e);
    e.v = 64'h4000000000000000; e.t = 4'h9; q32.push_back(e);
    @(posedge clk); #1;
    v8 = 1'b0; v32 = 1'b0;
    n = 1; l8 = 0; l32 = 0;
    while ((l8 == 0 || l32 == 0) && n < 40) begin
      if (ov8 && l8 == 0) l8 = n;
      if (ov32 && l32 == 0) l32 = n;
      @(posedge clk); #1;
      n++;
    end
    check("lat_w8_csa2", 64'(l8), 64'(LAT8));
    check("lat_w32_csa3", 64'(l32), 64'(LAT32));
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1)); t8 = 4'($urandom);
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1)); t32 = 4'($urandom);
      e.v = ref_mul(64'(a8), 64'(b8), s8, 8); e.t = t8; q8.push_back(e);
      e.v = ref_mul(64'(a32), 64'(b32), s32, 32); e.t = t32; q32.push_back(e);
      v8 = 1'b1; v32 = 1'b1;
      @(posedge clk); #1;
    end
    v8 = 1'b0; v32 = 1'b0;
    k = 0;
    while ((q8.size() != 0 || q32.size() != 0) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_w8", 64'(q8.size()), 64'd0);
    check("drain_w32", 64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
